// File: rtl/signal_buffer_writer.sv
// -----------------------------------------------------------------------------
// signal_buffer_writer
//
// Decimates two 12-bit sample streams (ECG, EMG) by averaging DECIM accepted
// samples. Each average goes into a circular window of NSAMP words in a shared
// memory. A BPM word is also forwarded to a fixed address. One memory write
// is issued per cycle, with fixed priority ECG > EMG > BPM.
//
// Handshake (ECG/EMG): a sample transfers on a rising edge where valid and
// ready are both 1. ready is low only while that channel's finished average
// is waiting for the write port, so at most one average per channel is ever
// buffered. BPM has no ready: bpm_valid simply (over)writes the BPM slot.
//
// Ports
//   clock, reset           rising-edge clock, synchronous active-high reset
//   ecg_valid/data/ready   ECG sample handshake (12-bit data)
//   emg_valid/data/ready   EMG sample handshake (12-bit data)
//   bpm_valid/bpm_value    BPM update pulse and 10-bit value
//   mem_wEn/addr/wdata     registered memory write port
//   ecg_wrap/emg_wrap      one-cycle pulse alongside the write at ptr=NSAMP-1
// -----------------------------------------------------------------------------
module signal_buffer_writer #(
  parameter int unsigned DECIM    = 4,
  parameter int unsigned NSAMP    = 320,
  parameter logic [11:0] ECG_BASE = 12'h559,
  parameter logic [11:0] EMG_BASE = 12'h6AD,
  parameter logic [11:0] BPM_ADDR = 12'd1704
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ecg_valid,
  input  logic [11:0] ecg_data,
  output logic        ecg_ready,
  input  logic        emg_valid,
  input  logic [11:0] emg_data,
  output logic        emg_ready,
  input  logic        bpm_valid,
  input  logic [9:0]  bpm_value,
  output logic        mem_wEn,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        ecg_wrap,
  output logic        emg_wrap
);

  localparam int          LOG2     = $clog2(DECIM);
  localparam logic [4:0]  CNT_LAST = 5'(DECIM - 1);
  localparam logic [8:0]  PTR_LAST = 9'(NSAMP - 1);
  localparam int          ECG      = 0;
  localparam int          EMG      = 1;

  // Per-channel state, index ECG=0 / EMG=1
  logic [15:0] acc_q  [2];
  logic [15:0] acc_d  [2];
  logic [4:0]  cnt_q  [2];
  logic [4:0]  cnt_d  [2];
  logic [11:0] slot_q [2];
  logic [11:0] slot_d [2];
  logic [8:0]  ptr_q  [2];
  logic [8:0]  ptr_d  [2];
  logic [1:0]  pend_q, pend_d;

  logic [1:0]  in_valid;
  logic [11:0] in_data [2];
  logic [15:0] sum     [2];
  logic [15:0] shifted [2];

  logic        bpm_pend_q, bpm_pend_d;
  logic [9:0]  bpm_slot_q, bpm_slot_d;

  logic        wen_q, wen_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ecg_wrap_q, ecg_wrap_d;
  logic        emg_wrap_q, emg_wrap_d;

  assign in_valid    = {emg_valid, ecg_valid};
  assign in_data[ECG] = ecg_data;
  assign in_data[EMG] = emg_data;

  always_comb begin
    pend_d     = pend_q;
    bpm_pend_d = bpm_pend_q;
    bpm_slot_d = bpm_slot_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ecg_wrap_d = 1'b0;
    emg_wrap_d = 1'b0;

    // Accumulate. A channel cannot accept while pending and cannot be granted
    // unless pending, so accept and grant never touch the same channel in
    // the same cycle.
    for (int c = 0; c < 2; c++) begin
      acc_d[c]   = acc_q[c];
      cnt_d[c]   = cnt_q[c];
      slot_d[c]  = slot_q[c];
      ptr_d[c]   = ptr_q[c];
      sum[c]     = acc_q[c] + {4'b0, in_data[c]};
      shifted[c] = sum[c] >> LOG2;
      if (in_valid[c] && !pend_q[c]) begin
        if (cnt_q[c] == CNT_LAST) begin
          slot_d[c] = shifted[c][11:0];
          acc_d[c]  = '0;
          cnt_d[c]  = '0;
          pend_d[c] = 1'b1;
        end else begin
          acc_d[c] = sum[c];
          cnt_d[c] = cnt_q[c] + 5'd1;
        end
      end
    end

    // Fixed-priority grant; the write itself appears one cycle later
    if (pend_q[ECG]) begin
      pend_d[ECG] = 1'b0;
      ptr_d[ECG]  = (ptr_q[ECG] == PTR_LAST) ? 9'd0 : ptr_q[ECG] + 9'd1;
      wen_d       = 1'b1;
      addr_d      = ECG_BASE + {3'b0, ptr_q[ECG]};
      wdata_d     = {20'b0, slot_q[ECG]};
      ecg_wrap_d  = (ptr_q[ECG] == PTR_LAST);
    end else if (pend_q[EMG]) begin
      pend_d[EMG] = 1'b0;
      ptr_d[EMG]  = (ptr_q[EMG] == PTR_LAST) ? 9'd0 : ptr_q[EMG] + 9'd1;
      wen_d       = 1'b1;
      addr_d      = EMG_BASE + {3'b0, ptr_q[EMG]};
      wdata_d     = {20'b0, slot_q[EMG]};
      emg_wrap_d  = (ptr_q[EMG] == PTR_LAST);
    end else if (bpm_pend_q) begin
      bpm_pend_d = 1'b0;
      wen_d      = 1'b1;
      addr_d     = BPM_ADDR;
      wdata_d    = {22'b0, bpm_slot_q};
    end

    // Evaluated after the grant so a new value arriving in the grant cycle
    // stays pending while the old value is written.
    if (bpm_valid) begin
      bpm_slot_d = bpm_value;
      bpm_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        acc_q[c]  <= '0;
        cnt_q[c]  <= '0;
        slot_q[c] <= '0;
        ptr_q[c]  <= '0;
      end
      pend_q     <= '0;
      bpm_pend_q <= 1'b0;
      bpm_slot_q <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ecg_wrap_q <= 1'b0;
      emg_wrap_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        acc_q[c]  <= acc_d[c];
        cnt_q[c]  <= cnt_d[c];
        slot_q[c] <= slot_d[c];
        ptr_q[c]  <= ptr_d[c];
      end
      pend_q     <= pend_d;
      bpm_pend_q <= bpm_pend_d;
      bpm_slot_q <= bpm_slot_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ecg_wrap_q <= ecg_wrap_d;
      emg_wrap_q <= emg_wrap_d;
    end
  end

  assign ecg_ready = !pend_q[ECG];
  assign emg_ready = !pend_q[EMG];
  assign mem_wEn   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign ecg_wrap  = ecg_wrap_q;
  assign emg_wrap  = emg_wrap_q;

endmodule

// File: tb/tb_signal_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_signal_buffer_writer
//
// Directed bench for signal_buffer_writer with default parameters (DECIM=4,
// NSAMP=320). Inputs change 1 time unit after the rising edge; outputs are
// checked there by directed steps and at the falling edge by the write
// scoreboard, which pops one expected {ecg_wrap, emg_wrap, addr, data} record
// per observed write.
// -----------------------------------------------------------------------------
module tb_signal_buffer_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ecg_valid, emg_valid, bpm_valid;
  logic [11:0] ecg_data, emg_data;
  logic [9:0]  bpm_value;
  logic        ecg_ready, emg_ready;
  logic        mem_wEn;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        ecg_wrap, emg_wrap;

  int checks = 0;
  int errors = 0;

  logic [45:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  signal_buffer_writer dut (
    .clock     (clock),
    .reset     (reset),
    .ecg_valid (ecg_valid),
    .ecg_data  (ecg_data),
    .ecg_ready (ecg_ready),
    .emg_valid (emg_valid),
    .emg_data  (emg_data),
    .emg_ready (emg_ready),
    .bpm_valid (bpm_valid),
    .bpm_value (bpm_value),
    .mem_wEn   (mem_wEn),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .ecg_wrap  (ecg_wrap),
    .emg_wrap  (emg_wrap)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [45:0] rec(input logic ew, input logic mw,
                                      input logic [11:0] a, input logic [31:0] d);
    return {ew, mw, a, d};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_wEn) begin
        if (exp_q.size() == 0) check_eq("unexpected_write", {20'b0, mem_addr, mem_wdata}, 64'd0);
        else check_eq("write", {18'b0, ecg_wrap, emg_wrap, mem_addr, mem_wdata}, {18'b0, exp_q.pop_front()});
      end else if (ecg_wrap || emg_wrap) begin
        check_eq("stray_wrap", {62'b0, ecg_wrap, emg_wrap}, 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  // Presents one sample and returns just after the edge that accepted it;
  // valid is left high for back-to-back use.
  task automatic send(input int ch, input logic [11:0] d);
    int budget = 0;
    if (ch == 0) begin ecg_valid = 1'b1; ecg_data = d; end
    else         begin emg_valid = 1'b1; emg_data = d; end
    while (((ch == 0) ? !ecg_ready : !emg_ready) && budget < 20) begin
      tick();
      budget++;
    end
    if (budget >= 20) check_eq("ready_timeout", 64'd0, 64'd1);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ecg_valid = 1'b0;
    emg_valid = 1'b0;
    bpm_valid = 1'b0;
    tick();
    tick();
    check_eq("rst_wen",       mem_wEn,   0);
    check_eq("rst_addr",      mem_addr,  0);
    check_eq("rst_wdata",     mem_wdata, 0);
    check_eq("rst_wraps",     {ecg_wrap, emg_wrap}, 0);
    check_eq("rst_readys",    {ecg_ready, emg_ready}, 2'b11);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ecg_data  = '0;
    emg_data  = '0;
    bpm_value = '0;
    do_reset();

    // Four ECG samples on consecutive cycles -> 250 at 0x559
    exp_q.push_back(rec(1'b0, 1'b0, 12'h559, 32'd250));
    send(0, 12'd100);
    send(0, 12'd200);
    send(0, 12'd300);
    send(0, 12'd400);
    ecg_valid = 1'b0;
    check_eq("s1_ready_low", ecg_ready, 0);
    check_eq("s1_no_wen_yet", mem_wEn, 0);
    tick();
    check_eq("s1_wen",   mem_wEn,   1);
    check_eq("s1_addr",  mem_addr,  12'h559);
    check_eq("s1_data",  mem_wdata, 32'd250);
    check_eq("s1_ready_back", ecg_ready, 1);
    tick();
    check_eq("s1_wen_off", mem_wEn, 0);

    // ECG and EMG complete together: ECG first, EMG next cycle
    exp_q.push_back(rec(1'b0, 1'b0, 12'h55A, 32'd25));
    exp_q.push_back(rec(1'b0, 1'b0, 12'h6AD, 32'd2));
    for (int k = 0; k < 4; k++) begin
      ecg_valid = 1'b1; ecg_data = 12'(10 * (k + 1));
      emg_valid = 1'b1; emg_data = 12'(k + 1);
      tick();
    end
    ecg_valid = 1'b0;
    emg_valid = 1'b0;
    check_eq("s2_readys_low", {ecg_ready, emg_ready}, 2'b00);
    tick();
    check_eq("s2_ecg_addr", mem_addr, 12'h55A);
    check_eq("s2_readys", {ecg_ready, emg_ready}, 2'b10);
    tick();
    check_eq("s2_emg_wen",  mem_wEn,  1);
    check_eq("s2_emg_addr", mem_addr, 12'h6AD);
    check_eq("s2_emg_ready", emg_ready, 1);
    tick();

    // Valid held while not ready: the 1000 must not be absorbed
    exp_q.push_back(rec(1'b0, 1'b0, 12'h55B, 32'd4));
    exp_q.push_back(rec(1'b0, 1'b0, 12'h55C, 32'd8));
    for (int k = 0; k < 4; k++) send(0, 12'd4);
    ecg_data = 12'd1000;
    check_eq("s5_ready_low", ecg_ready, 0);
    tick();
    for (int k = 0; k < 4; k++) send(0, 12'd8);
    ecg_valid = 1'b0;
    drain(4);

    // BPM updates while ECG/EMG own the port: only the latest (75) lands
    exp_q.push_back(rec(1'b0, 1'b0, 12'h55D, 32'd0));
    exp_q.push_back(rec(1'b0, 1'b0, 12'h6AE, 32'd4095));
    exp_q.push_back(rec(1'b0, 1'b0, 12'd1704, 32'd75));
    for (int k = 0; k < 4; k++) begin
      ecg_valid = 1'b1; ecg_data = 12'd0;
      emg_valid = 1'b1; emg_data = 12'hFFF;
      tick();
    end
    ecg_valid = 1'b0;
    emg_valid = 1'b0;
    bpm_valid = 1'b1; bpm_value = 10'd72;
    tick();
    bpm_value = 10'd75;
    tick();
    bpm_valid = 1'b0;
    drain(5);

    // bpm_valid in the BPM grant cycle: old value written, new one follows
    exp_q.push_back(rec(1'b0, 1'b0, 12'd1704, 32'd60));
    exp_q.push_back(rec(1'b0, 1'b0, 12'd1704, 32'd61));
    bpm_valid = 1'b1; bpm_value = 10'd60;
    tick();
    bpm_value = 10'd61;
    tick();
    bpm_valid = 1'b0;
    drain(4);
    check_eq("idle_wen",   mem_wEn,   0);
    check_eq("hold_addr",  mem_addr,  12'd1704);
    check_eq("hold_wdata", mem_wdata, 32'd61);

    // Reset with ECG pending and EMG half-accumulated: nothing is written
    for (int k = 0; k < 4; k++) begin
      ecg_valid = 1'b1; ecg_data = 12'd50;
      emg_valid = (k < 2); emg_data = 12'd900;
      tick();
    end
    do_reset();
    exp_q.push_back(rec(1'b0, 1'b0, 12'h559, 32'd8));
    exp_q.push_back(rec(1'b0, 1'b0, 12'h6AD, 32'd12));
    for (int k = 0; k < 4; k++) send(0, 12'd8);
    ecg_valid = 1'b0;
    for (int k = 0; k < 4; k++) send(1, 12'd12);
    emg_valid = 1'b0;
    drain(4);

    // Full ECG window: write 320 at 0x698 pulses ecg_wrap, then back to 0x559
    do_reset();
    for (int i = 0; i <= 320; i++) begin
      logic [11:0] v;
      v = 12'((i * 13) & 12'hFFF);
      exp_q.push_back(rec(i == 319, 1'b0,
                          (i == 320) ? 12'h559 : 12'(12'h559 + i), {20'b0, v}));
      for (int k = 0; k < 4; k++) send(0, v);
    end
    ecg_valid = 1'b0;
    drain(4);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/signal_buffer_writer.md
SIGNAL_BUFFER_WRITER -- requirements
Module: signal_buffer_writer

Interface
REQ-001 SHALL have parameter DECIM, default 4: number of accepted samples averaged per stored sample; power of 2, range 1..16.
REQ-002 SHALL have parameter NSAMP, default 320: number of stored samples per channel window.
REQ-003 SHALL have parameter ECG_BASE, default 12'h559: address of ECG window entry 0.
REQ-004 SHALL have parameter EMG_BASE, default 12'h6AD: address of EMG window entry 0.
REQ-005 SHALL have parameter BPM_ADDR, default 12'd1704: address of the BPM word.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have ports ecg_valid (input, 1), ecg_data (input, 12) and ecg_ready (output, 1): the ECG sample handshake.
REQ-009 SHALL have ports emg_valid (input, 1), emg_data (input, 12) and emg_ready (output, 1): the EMG sample handshake.
REQ-010 SHALL have ports bpm_valid (input, 1) and bpm_value (input, 10): the BPM update pulse and its value; there is no ready.
REQ-011 SHALL have ports mem_wEn (output, 1), mem_addr (output, 12) and mem_wdata (output, 32): the shared memory write port, all registered.
REQ-012 SHALL have ports ecg_wrap and emg_wrap (outputs, 1 each): one-cycle pulses on window wrap.

Function
REQ-013 SHALL accept a sample on a channel in any cycle where valid and ready are both 1; the sample SHALL be added to that channel's 16-bit accumulator and the channel's sample count incremented.
REQ-014 SHALL, on the DECIM-th accepted sample of a channel, load the channel's pending slot at the end of that cycle with (accumulator + sample) >> log2(DECIM), truncated, and SHALL clear the accumulator and count.
REQ-015 SHALL drive ready = !pending for each channel.
REQ-016 SHALL arbitrate one write per cycle with fixed priority: ECG pending, then EMG pending, then BPM pending.
REQ-017 SHALL register the granted write: a grant in cycle K SHALL drive mem_wEn=1 with the matching mem_addr/mem_wdata in cycle K+1, and SHALL clear that pending flag at the end of K.
REQ-018 SHALL, as a result, show the write two cycles after the DECIM-th handshake when the channel is uncontested.
REQ-019 SHALL drive mem_wEn=0 in any cycle following a cycle with no grant; mem_addr and mem_wdata then hold their previous values.
REQ-020 SHALL set the ECG write address to ECG_BASE + ecg_ptr and the EMG write address to EMG_BASE + emg_ptr; ptr is 9 bits, range 0..NSAMP-1.
REQ-021 SHALL set mem_wdata for ECG/EMG writes to {20'b0, avg[11:0]}.
REQ-022 SHALL increment ptr on each granted write for that channel; a write at ptr = NSAMP-1 SHALL set ptr to 0 and pulse that channel's wrap output in the same cycle as its mem_wEn.
REQ-023 SHALL capture bpm_value into the BPM slot and set bpm pending when bpm_valid=1; a new bpm_valid while still pending SHALL overwrite the slot (latest value wins).
REQ-024 SHALL, when bpm_valid coincides with the BPM grant cycle, write the old value and leave the new value pending.
REQ-025 SHALL write the BPM word to BPM_ADDR with mem_wdata = {22'b0, bpm_value}.
REQ-026 SHALL, when DECIM=1, store every accepted sample unmodified.

Reset
REQ-027 SHALL, while reset=1, clear the accumulators, counts, ptrs and pending flags, and drive mem_wEn=0, mem_addr=0, mem_wdata=0, ecg_wrap=0, emg_wrap=0, ecg_ready=1 and emg_ready=1 in the following cycle.
REQ-028 SHALL, on reset mid-accumulation or with writes pending, discard partial sums and pending data; no write SHALL be issued for them.

Verification
REQ-029 SHALL pass this scenario: DECIM=4; ECG samples 100, 200, 300, 400 on consecutive cycles -> mem_wEn one cycle, addr 12'h559, data 250, two cycles after the 4th handshake; ecg_ready low for exactly one cycle.
REQ-030 SHALL pass this scenario: ECG and EMG both complete in the same cycle -> ECG write at ptr address, EMG write on the next cycle at 12'h6AD; emg_ready stays low one extra cycle.
REQ-031 SHALL pass this scenario: 320 ECG averages written -> 320th write at 12'h698 with ecg_wrap=1; the next write at 12'h559.
REQ-032 SHALL pass this scenario: bpm_valid with 72, then 75 one cycle later while ECG writes hold the port -> single BPM write of 75 to 1704.
REQ-033 SHALL pass this scenario: reset asserted after 2 of 4 samples -> no write; next 4 samples 8, 8, 8, 8 produce data 8 at 12'h559.
REQ-034 SHALL pass this scenario: held ecg_valid with ecg_ready low -> no sample accepted; the accumulator is unchanged.
